// File: rtl/riscv_timer.sv
// riscv_timer: RISC-V style machine timer peripheral.
// Holds the 64-bit mtime counter and the mtimecmp compare register. Both are
// exposed on a word-wide request/ack register bus together with a control
// register (enable + prescale) and a sticky pending flag. A one-cycle
// timer_irq pulse is emitted each time mtime reaches mtimecmp.
module riscv_timer #(
  parameter int unsigned PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic        EN_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        timer_irq
);

  // Word index of the register map (byte offset / 4).
  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_STATUS   = 3'd5,
    REG_RSVD0    = 3'd6,
    REG_RSVD1    = 3'd7
  } reg_idx_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_enable;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_div;
  logic                  r_pending;
  logic                  r_cmp_q;
  logic                  r_irq;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_rdata;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  reg_idx_e w_idx;
  logic     w_wr;
  logic     w_rd;
  logic     w_mapped;
  logic     w_wr_mtime_lo;
  logic     w_wr_mtime_hi;
  logic     w_wr_cmp_lo;
  logic     w_wr_cmp_hi;
  logic     w_wr_cmp;
  logic     w_wr_ctrl;
  logic     w_wr_status;
  logic     w_clr_pending;

  // Byte-lane bits are ignored: only whole-word accesses exist.
  logic     w_unused_addr;
  assign w_unused_addr = ^addr[1:0];

  assign w_idx         = reg_idx_e'(addr[4:2]);
  assign w_wr          = req &  we;
  assign w_rd          = req & ~we;
  assign w_mapped      = (w_idx != REG_RSVD0) && (w_idx != REG_RSVD1);
  assign w_wr_mtime_lo = w_wr && (w_idx == REG_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_idx == REG_MTIME_HI);
  assign w_wr_cmp_lo   = w_wr && (w_idx == REG_CMP_LO);
  assign w_wr_cmp_hi   = w_wr && (w_idx == REG_CMP_HI);
  assign w_wr_cmp      = w_wr_cmp_lo | w_wr_cmp_hi;
  assign w_wr_ctrl     = w_wr && (w_idx == REG_CTRL);
  assign w_wr_status   = w_wr && (w_idx == REG_STATUS);
  assign w_clr_pending = w_wr_status & wdata[0];

  // ---------------------------------------------------------------------------
  // Prescaler and compare conditions
  // ---------------------------------------------------------------------------
  logic w_tick;
  logic w_cond;
  logic w_fire;

  // mtime advances on the cycle the divider has reached the prescale value.
  assign w_tick = r_enable && (r_div == r_prescale);
  // Unsigned 64-bit compare on the current register values.
  assign w_cond = (r_mtime >= r_mtimecmp);
  // Rising edge of the compare condition, relative to last cycle's sample.
  assign w_fire = w_cond & ~r_cmp_q;

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_rd_data;

  // Assemble the ctrl readback; undefined bits read as zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_ctrl_rd                     = '0;
    w_ctrl_rd[0]                  = r_enable;
    w_ctrl_rd[8 +: PRESCALE_W]    = r_prescale;
  end

  // Select the addressed register; unmapped offsets read as zero.
  always_comb begin
    w_rd_data = '0;
    unique case (w_idx)
      REG_MTIME_LO: w_rd_data = r_mtime[31:0];
      REG_MTIME_HI: w_rd_data = r_mtime[63:32];
      REG_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
      REG_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
      REG_CTRL:     w_rd_data = w_ctrl_rd;
      REG_STATUS:   w_rd_data = {31'd0, r_pending};
      REG_RSVD0,
      REG_RSVD1:    w_rd_data = '0;
      default:      w_rd_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Bus response: ack, err and read data appear exactly one cycle after req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= req;
      r_err   <= req & ~w_mapped;
      r_rdata <= w_rd ? w_rd_data : 32'd0;
    end
  end

  // Control register: enable bit and prescale field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable   <= EN_RESET;
      r_prescale <= '0;
    end else if (w_wr_ctrl) begin
      r_enable   <= wdata[0];
      r_prescale <= wdata[8 +: PRESCALE_W];
    end
  end

  // Prescale divider: counts 0..prescale while enabled, restarts on ctrl write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_wr_ctrl) begin
      r_div <= '0;
    end else if (r_enable) begin
      if (w_tick) r_div <= '0;
      else        r_div <= r_div + 1'b1;
    end
  end

  // mtime: a bus write to either half wins and suppresses that cycle's tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= wdata;
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp: written one half at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtimecmp <= CMP_RESET;
    end else if (w_wr_cmp_lo) begin
      r_mtimecmp[31:0] <= wdata;
    end else if (w_wr_cmp_hi) begin
      r_mtimecmp[63:32] <= wdata;
    end
  end

  // Compare edge detector; a compare write re-arms it so a true cond re-fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_q <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_cmp_q <= w_wr_cmp ? 1'b0 : w_cond;
      r_irq   <= w_fire;
    end
  end

  // Sticky pending flag; a new fire beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (w_fire) begin
      r_pending <= 1'b1;
    end else if (w_clr_pending) begin
      r_pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign err       = r_err;
  assign timer_irq = r_irq;

endmodule

// File: tb/tb_riscv_timer.sv
// tb_riscv_timer: scoreboard bench for riscv_timer.
// The driver advances a behavioural timer model one cycle per bus cycle and
// queues the expected bus response and irq level; a negedge monitor pops and
// compares whatever the DUT presents.
module tb_riscv_timer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        timer_irq;

  riscv_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int irq_count = 0;

  // Expected responses: {err, rdata} per request, irq level per cycle.
  logic [32:0] resp_q[$];
  logic        irq_q[$];

  // Behavioural model state.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [7:0]  m_ps;
  logic [7:0]  m_phase;     // enabled cycles since the divider last restarted
  logic        m_pend;
  logic        m_prev_cond; // compare condition seen on the previous cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mtime     = 64'd0;
    m_cmp       = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en        = 1'b1;
    m_ps        = 8'd0;
    m_phase     = 8'd0;
    m_pend      = 1'b0;
    m_prev_cond = 1'b0;
    resp_q.delete();
    irq_q.delete();
  endtask

  // One bus cycle: drive inputs, advance the model, queue expectations.
  task automatic cycle(input logic rq, input logic w, input logic [4:0] a, input logic [31:0] d);
    logic [2:0]  idx;
    logic [31:0] rd;
    logic        er;
    logic        cond;
    logic        fire;
    logic        tick;
    idx   = a[4:2];
    req   = rq;
    we    = w;
    addr  = a;
    wdata = d;
    er    = rq && (idx >= 3'd6);
    rd    = 32'd0;
    if (rq && !w) begin
      case (idx)
        3'd0: rd = m_mtime[31:0];
        3'd1: rd = m_mtime[63:32];
        3'd2: rd = m_cmp[31:0];
        3'd3: rd = m_cmp[63:32];
        3'd4: rd = {16'd0, m_ps, 7'd0, m_en};
        3'd5: rd = {31'd0, m_pend};
        default: rd = 32'd0;
      endcase
    end
    cond = (m_mtime >= m_cmp);
    fire = cond && !m_prev_cond;
    tick = m_en && (m_phase == m_ps);
    // Pending: a fire is the stronger event.
    if (fire) m_pend = 1'b1;
    else if (rq && w && idx == 3'd5 && d[0]) m_pend = 1'b0;
    // Divider phase.
    if (rq && w && idx == 3'd4) m_phase = 8'd0;
    else if (m_en) m_phase = tick ? 8'd0 : m_phase + 8'd1;
    // Counter: writes hold the count.
    if (rq && w && idx == 3'd0)      m_mtime = {m_mtime[63:32], d};
    else if (rq && w && idx == 3'd1) m_mtime = {d, m_mtime[31:0]};
    else if (tick)                   m_mtime = m_mtime + 64'd1;
    // Compare register; writing it forgets the previous condition.
    if (rq && w && idx == 3'd2)      m_cmp = {m_cmp[63:32], d};
    else if (rq && w && idx == 3'd3) m_cmp = {d, m_cmp[31:0]};
    m_prev_cond = (rq && w && (idx == 3'd2 || idx == 3'd3)) ? 1'b0 : cond;
    // Control.
    if (rq && w && idx == 3'd4) begin
      m_en = d[0];
      m_ps = d[15:8];
    end
    @(posedge clk);
    if (rq) resp_q.push_back({er, rd});
    irq_q.push_back(fire);
    #1;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    cycle(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 5'd0;
    wdata = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare everything the DUT shows against the queued model output.
  always @(negedge clk) begin
    logic [32:0] r;
    logic        e;
    if (rst_n) begin
      if (irq_q.size() > 0) begin
        e = irq_q.pop_front();
        check("timer_irq", 64'(timer_irq), 64'(e));
      end
      if (timer_irq) irq_count++;
      if (ack) begin
        if (resp_q.size() == 0) begin
          check("ack_unexpected", 64'(ack), 64'd0);
        end else begin
          r = resp_q.pop_front();
          check("rdata", 64'(rdata), 64'(r[31:0]));
          check("err", 64'(err), 64'(r[32]));
        end
      end else begin
        check("idle_outputs", 64'({err, rdata}), 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] v;
    logic [2:0]  sel;
    do_reset();

    // Reset in the middle of a read: the response must be dropped.
    req = 1'b1; we = 1'b0; addr = 5'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_drops_ack", 64'(ack), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_irq", 64'(timer_irq), 64'd0);
    model_reset();
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values and free-running count.
    rd(5'h08); rd(5'h0C); rd(5'h10); rd(5'h14); rd(5'h00); rd(5'h00);

    // Basic fire at mtime == 20.
    irq_count = 0;
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd20);
    idle(30);
    check("basic_fire_pulses", 64'(irq_count), 64'd1);
    rd(5'h14);
    wr(5'h14, 32'd1);
    rd(5'h14);

    // Prescale of 3, then frozen.
    wr(5'h10, 32'h0000_0301);
    rd(5'h10);
    for (int i = 0; i < 12; i++) begin
      rd(5'h00);
      idle(1);
    end
    wr(5'h10, 32'd0);
    rd(5'h00);
    idle(50);
    rd(5'h00);
    rd(5'h10);

    // Carry from low to high half.
    wr(5'h10, 32'd1);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h04, 32'd0);
    idle(1);
    rd(5'h04);
    rd(5'h00);
    // Write priority over a tick.
    wr(5'h00, 32'd5);
    rd(5'h00);
    rd(5'h04);

    // Re-arm by rewriting mtimecmp lo with the same value.
    irq_count = 0;
    idle(5);
    check("no_refire_idle", 64'(irq_count), 64'd0);
    wr(5'h08, 32'd20);
    idle(5);
    check("rearm_pulses", 64'(irq_count), 64'd1);
    irq_count = 0;
    idle(100);
    check("quiet_100", 64'(irq_count), 64'd0);

    // Bus edge cases.
    rd(5'h18);
    wr(5'h1C, 32'hDEAD_BEEF);
    rd(5'h1C);
    rd(5'h00);
    rd(5'h00);
    rd(5'h03);

    // Clear of status on the same cycle as a new fire.
    wr(5'h14, 32'd1);
    rd(5'h14);
    wr(5'h08, 32'd20);
    wr(5'h14, 32'd1);
    rd(5'h14);
    wr(5'h14, 32'd1);
    rd(5'h14);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2: rd(5'(sel) << 2);
        3: begin
          v = m_mtime[31:0] + $urandom_range(0, 40);
          wr(5'h08, v);
        end
        4: wr(5'h0C, m_mtime[63:32]);
        5: begin
          v = {16'd0, 8'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 3) != 0)};
          wr(5'h10, v);
        end
        6: wr(5'h14, 32'($urandom_range(0, 1)));
        7: if ($urandom_range(0, 3) == 0) wr(5'h00, $urandom) ;
           else idle(1);
        default: idle(1);
      endcase
    end
    wr(5'h10, 32'd1);
    rd(5'h10);
    idle(3);
    check("drain", 64'(resp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
